// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake and FIFO write-port bundle; master = arbiter side.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) ();
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_w_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          grant_active;
    logic [ID_W-1:0]               grant_id;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_w_en, fifo_data_in, grant_active, grant_id
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_w_en, fifo_data_in, grant_active, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_priority_pick.sv
// Rotating-priority encoder: first set request at or after i_ptr, wrapping.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_found,
    output logic [ID_W-1:0]    o_idx
);
    logic [ID_W-1:0] w_cand;

    function automatic logic [ID_W-1:0] f_rot(input logic [ID_W-1:0] base, input int ofs);
        int sum;
        sum = int'(base) + ofs;
        if (sum >= NUM_REQ) sum -= NUM_REQ;
        return ID_W'(sum);
    endfunction

    // Scan from farthest to nearest so the closest hit to i_ptr is assigned last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = f_rot(i_ptr, k);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port, with bounded bursts per grant.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_wr_arbiter_if.master bus
);
    localparam int ID_W = id_width(NUM_REQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    arb_state_t            r_state, w_state_nxt;
    logic [ID_W-1:0]       r_grant_id, w_grant_id_nxt;
    logic [ID_W-1:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [BC_W-1:0]       r_beat_cnt, w_beat_cnt_nxt;
    logic [ID_W-1:0]       w_release_ptr, w_pick_ptr, w_pick_idx;
    logic                  w_active, w_beat, w_release, w_pick_found;
    logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_slice[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_active      = (r_state == ARB_GRANT);
    assign w_beat        = w_active && !bus.fifo_full && bus.req_valid[r_grant_id];
    assign w_release     = w_active && ((w_beat && (r_beat_cnt == LAST_BEAT)) ||
                                        !bus.req_valid[r_grant_id]);
    assign w_release_ptr = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
    // On release the next winner is chosen from the advanced pointer in the same cycle.
    assign w_pick_ptr    = w_active ? w_release_ptr : r_rr_ptr;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req   (bus.req_valid),
        .i_ptr   (w_pick_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_id_nxt = r_grant_id;
        w_beat_cnt_nxt = r_beat_cnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt    = ARB_GRANT;
                    w_grant_id_nxt = w_pick_idx;
                    w_beat_cnt_nxt = '0;
                end
            end
            ARB_GRANT: begin
                if (w_beat) w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                if (w_release) begin
                    w_rr_ptr_nxt   = w_release_ptr;
                    w_beat_cnt_nxt = '0;
                    if (w_pick_found) w_grant_id_nxt = w_pick_idx;
                    else              w_state_nxt    = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (w_active && !bus.fifo_full) bus.req_ready[r_grant_id] = 1'b1;
    end

    assign bus.fifo_w_en    = w_beat;
    assign bus.fifo_data_in = w_active ? w_slice[r_grant_id] : '0;
    assign bus.grant_active = w_active;
    assign bus.grant_id     = r_grant_id;
endmodule
